ahb_bram_ctrl: RTL
==================

AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the BRAM word-address width (2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have port HCLK, input, 1 bit: the single clock, rising edge, shared with the BRAM.
REQ-003 SHALL have port HRESETn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR 32, HTRANS 2, HSIZE 3, HWRITE 1, HWDATA 32, HREADY 1.
REQ-005 SHALL have AHB-Lite slave outputs: HREADYOUT 1, HRDATA 32, HRESP 1.
REQ-006 SHALL have BRAM outputs: BRAM_WADDR ADDR_WIDTH, BRAM_WDATA 32, BRAM_WE 4 (byte strobes), BRAM_RADDR ADDR_WIDTH.
REQ-007 SHALL have BRAM input BRAM_RDATA, 32 bits, registered read data with 1-cycle latency after BRAM_RADDR.

Function
REQ-008 Address phase SHALL be accepted only when HSEL=1, HTRANS[1]=1 and HREADY=1; otherwise the cycle is idle.
REQ-009 Word index SHALL be HADDR[ADDR_WIDTH+1:2]; upper HADDR bits SHALL be ignored.
REQ-010 Byte lanes: HSIZE=0 -> 4'b0001<<HADDR[1:0]; HSIZE=1 -> 4'b0011 if HADDR[1]=0, else 4'b1100; HSIZE=2 -> 4'b1111; other HSIZE -> 4'b0000 (no write).
REQ-011 On an accepted write, the address index and lane mask SHALL be registered; in the following data phase BRAM_WADDR = registered index, BRAM_WDATA = HWDATA, BRAM_WE = registered mask, for exactly one cycle.
REQ-012 BRAM_WE SHALL be 4'b0000 in every cycle that is not a write data phase.
REQ-013 BRAM_RADDR SHALL equal the HADDR word index combinationally during an accepted read address phase, so that read data appears in the next cycle with zero wait states.
REQ-014 HRDATA SHALL present BRAM_RDATA (or the merged value of REQ-020) during the read data phase; its value in other cycles is don't-care.
REQ-015 HRESP SHALL be constantly 0 (OKAY).
REQ-016 Writes SHALL always complete with zero wait states (HREADYOUT=1).
REQ-017 Hazard: a read whose address phase coincides with a write data phase to the same word index is a RAW hit; BRAM returns pre-write data for it.
REQ-018 A RAW hit to a different word index, or a write with mask 4'b0000, SHALL NOT be treated as a hazard.
REQ-019 Back-to-back writes, back-to-back reads and write-read-write sequences SHALL sustain one transfer per cycle except as stated in REQ-021.
REQ-020 (forwarding build) On a RAW hit, the write's data and mask SHALL be registered, and in the read data phase HRDATA byte n = forwarded byte n where mask[n]=1, else BRAM_RDATA byte n; HREADYOUT stays 1.
REQ-021 (stall build) On a RAW hit, the controller SHALL enter state STALL: HREADYOUT=0 for exactly one cycle, BRAM_RADDR = registered read index, then return to state IDLE with HREADYOUT=1 and HRDATA = BRAM_RDATA holding the written bytes.
REQ-022 States (stall build): IDLE -> STALL on RAW hit; STALL -> IDLE unconditionally next cycle; no address phase is accepted while HREADYOUT=0.

Reset
REQ-023 While HRESETn=0: HREADYOUT=1, HRESP=0, BRAM_WE=0, HRDATA=0, state=IDLE, write-pending and forward flags cleared.
REQ-024 Reset asserted mid-transfer SHALL abandon any pending write (no BRAM_WE after release) and any stall.
REQ-025 The first cycle after release SHALL accept a new address phase.

Configuration
REQ-026 Macro AHB_BRAM_FWD_EN defined: RAW hits SHALL be resolved by forwarding per REQ-020, with no STALL state compiled.
REQ-027 Macro AHB_BRAM_FWD_EN undefined: RAW hits SHALL be resolved by the one-cycle stall per REQ-021/022, with no forwarding registers compiled.

Verification
REQ-028 Word write 0xDEADBEEF to 0x0000_0010, idle, read 0x10 -> BRAM_WE=4'b1111 at index 4 one cycle after address phase; HRDATA=0xDEADBEEF, no wait.
REQ-029 Byte write 0xAA to 0x13 over word 0x11223344, later word read 0x10 -> BRAM_WE=4'b1000; HRDATA=0xAA223344.
REQ-030 Halfword write 0x5566 to 0x22 immediately followed by a read of 0x20 (old 0x00000000) -> HRDATA=0x55660000; FWD_EN build: HREADYOUT never low; non-FWD build: HREADYOUT low for exactly 1 cycle.
REQ-031 Write 0x1 to 0x40 immediately followed by a read of 0x44 -> no stall, HRDATA = old content of 0x44.
REQ-032 HSEL=1, HTRANS=NONSEQ, HWRITE=1, HREADY=0 -> no BRAM_WE asserted; then HRESETn pulsed low during a write data phase -> BRAM_WE=0 and HREADYOUT=1 immediately.

Source files
------------

// File: rtl/ahb_bram_ctrl.sv
// rtl/ahb_bram_ctrl.sv - AHB-Lite slave to 1-cycle-latency BRAM bridge; define AHB_BRAM_FWD_EN for read-after-write forwarding instead of a one-cycle stall
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] BRAM_WADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_RADDR,
    input  logic [31:0]           BRAM_RDATA
);

    logic [ADDR_WIDTH-1:0] a_idx;
    logic [3:0]            a_mask;
    logic                  accept;
    logic                  raw_hit;
    logic                  hready_int;
    logic [31:0]           rd_data;

    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [3:0]            wmask_q, wmask_d;
    logic                  rd_phase_q, rd_phase_d;

`ifdef AHB_BRAM_FWD_EN
    logic                  fwd_q, fwd_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
`endif

    // Upper address bits and the SEQ/NONSEQ distinction carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    assign a_idx   = HADDR[ADDR_WIDTH+1:2];
`ifdef AHB_BRAM_FWD_EN
    assign hready_int = 1'b1;
`else
    assign hready_int = (state_q == ST_IDLE);
`endif
    // A wait state never accepts a new address phase, even if HREADY is misdriven
    assign accept  = HSEL & HTRANS[1] & HREADY & hready_int;
    // Only a real byte write to the very word being read can make BRAM return stale data
    assign raw_hit = accept & ~HWRITE & wr_pend_q & (|wmask_q) & (a_idx == waddr_q);

    assign HREADYOUT  = hready_int;
    assign HRESP      = 1'b0;
    assign BRAM_WADDR = waddr_q;
    assign BRAM_WDATA = HWDATA;
    assign BRAM_WE    = wr_pend_q ? wmask_q : 4'b0000;
    assign HRDATA     = rd_phase_q ? rd_data : 32'h0;

    // Byte-lane strobes from transfer size and low address bits
    always_comb begin
        a_mask = 4'b0000;
        case (HSIZE)
            3'd0:    a_mask = 4'b0001 << HADDR[1:0];
            3'd1:    a_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    a_mask = 4'b1111;
            default: a_mask = 4'b0000;
        endcase
    end

    // Read address: live index normally, the held index while re-reading after a stall
    always_comb begin
`ifdef AHB_BRAM_FWD_EN
        BRAM_RADDR = a_idx;
`else
        BRAM_RADDR = (state_q == ST_STALL) ? ridx_q : a_idx;
`endif
    end

    // Read data, with forwarded bytes overlaid on the stale BRAM word on a hit
    always_comb begin
        rd_data = BRAM_RDATA;
`ifdef AHB_BRAM_FWD_EN
        for (int n = 0; n < 4; n++) begin
            if (fwd_q && fwd_mask_q[n]) begin
                rd_data[8*n +: 8] = fwd_data_q[8*n +: 8];
            end
        end
`endif
    end

    // Next-state computation for the write pipeline and hazard handling
    always_comb begin
        wr_pend_d  = accept & HWRITE;
        waddr_d    = (accept & HWRITE) ? a_idx : waddr_q;
        wmask_d    = (accept & HWRITE) ? a_mask : wmask_q;
        rd_phase_d = accept & ~HWRITE;
`ifdef AHB_BRAM_FWD_EN
        fwd_d      = raw_hit;
        fwd_data_d = raw_hit ? HWDATA : fwd_data_q;
        fwd_mask_d = raw_hit ? wmask_q : fwd_mask_q;
`else
        state_d    = raw_hit ? ST_STALL : ST_IDLE;
        ridx_d     = raw_hit ? a_idx : ridx_q;
        if (state_q == ST_STALL) begin
            rd_phase_d = 1'b1;
        end
`endif
    end

    // All controller state; reset abandons pending writes, stalls and forwards
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_q  <= 1'b0;
            waddr_q    <= '0;
            wmask_q    <= 4'b0000;
            rd_phase_q <= 1'b0;
`ifdef AHB_BRAM_FWD_EN
            fwd_q      <= 1'b0;
            fwd_data_q <= 32'h0;
            fwd_mask_q <= 4'b0000;
`else
            state_q    <= ST_IDLE;
            ridx_q     <= '0;
`endif
        end else begin
            wr_pend_q  <= wr_pend_d;
            waddr_q    <= waddr_d;
            wmask_q    <= wmask_d;
            rd_phase_q <= rd_phase_d;
`ifdef AHB_BRAM_FWD_EN
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            fwd_mask_q <= fwd_mask_d;
`else
            state_q    <= state_d;
            ridx_q     <= ridx_d;
`endif
        end
    end

endmodule
